// File: rtl/seq_serializer_pkg.sv
// Shared types and constants for the preamble serializer: one-hot state codes,
// default frame geometry and the bit-counter width helper.
package seq_serializer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_PREAMBLE = 4'b0010,
    ST_DATA     = 4'b0100,
    ST_GAP      = 4'b1000
  } state_t;

  localparam int         DEF_DATA_W     = 8;
  localparam int         DEF_PRE_W      = 4;
  localparam logic [3:0] DEF_PREAMBLE   = 4'b1011;
  localparam int         DEF_GAP_CYCLES = 2;

  // Wide enough for the largest load value; never narrower than one bit.
  function automatic int cnt_width(input int pre_w, input int data_w, input int gap_cycles);
    int m;
    m = pre_w;
    if (data_w > m) m = data_w;
    if (gap_cycles > m) m = gap_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seq_preamble_serializer.sv
// Serializes a handshaked parallel word as preamble + MSB-first payload + zero gap.
// States: IDLE wait for word | PREAMBLE send pattern | DATA send payload | GAP send zeros
module seq_preamble_serializer
  import seq_serializer_pkg::*;
#(
  parameter int               DATA_W     = DEF_DATA_W,
  parameter int               PRE_W      = DEF_PRE_W,
  parameter logic [PRE_W-1:0] PREAMBLE   = PRE_W'(DEF_PREAMBLE),
  parameter int               GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              sequence_out,
  output logic              frame_active,
  output logic              done_pulse
);

  localparam int CW = cnt_width(PRE_W, DATA_W, GAP_CYCLES);

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [PRE_W-1:0]  pre_shift;
  logic              seq_q, seq_next;
  logic              done_q, done_next;
  logic              cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      shreg  <= '0;
      seq_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      shreg  <= shreg_next;
      seq_q  <= seq_next;
      done_q <= done_next;
    end
  end

  // The serial bit is computed one cycle early so sequence_out is a plain flop.
  always_comb begin
    state_next = ST_IDLE;
    cnt_next   = cnt;
    shreg_next = shreg;
    seq_next   = 1'b0;
    done_next  = 1'b0;
    pre_shift  = '0;
    case (state)
      ST_IDLE: begin
        if (data_valid) begin
          state_next = ST_PREAMBLE;
          cnt_next   = CW'(PRE_W - 1);
          shreg_next = data_in;
        end
      end
      ST_PREAMBLE: begin
        if (cnt_zero) begin
          state_next = ST_DATA;
          cnt_next   = CW'(DATA_W - 1);
        end else begin
          state_next = ST_PREAMBLE;
          cnt_next   = cnt - 1'b1;
        end
      end
      ST_DATA: begin
        shreg_next = shreg << 1;
        if (cnt_zero) begin
          state_next = ST_GAP;
          cnt_next   = CW'(GAP_CYCLES - 1);
          done_next  = 1'b1;
        end else begin
          state_next = ST_DATA;
          cnt_next   = cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_GAP;
          cnt_next   = cnt - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        shreg_next = '0;
      end
    endcase
    case (state_next)
      ST_PREAMBLE: begin
        pre_shift = PREAMBLE >> cnt_next;
        seq_next  = pre_shift[0];
      end
      ST_DATA: seq_next = shreg_next[DATA_W-1];
      default: seq_next = 1'b0;
    endcase
  end

  // Illegal encodings decode as IDLE outputs.
  always_comb begin
    frame_active = (state == ST_PREAMBLE) || (state == ST_DATA) || (state == ST_GAP);
    data_ready   = !frame_active;
    sequence_out = seq_q;
    done_pulse   = done_q;
  end

endmodule

// File: tb/tb_seq_preamble_serializer.sv
// Directed vector bench for seq_preamble_serializer, including a "1011" Moore
// detector loopback and a 16-bit payload / 3-cycle gap instance.
module tb_seq_preamble_serializer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready, sequence_out, frame_active, done_pulse;
  logic [15:0] data_in16;
  logic        data_valid16;
  logic        data_ready16, sequence_out16, frame_active16, done_pulse16;

  always #5 clock = ~clock;

  seq_preamble_serializer u_dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .sequence_out(sequence_out),
    .frame_active(frame_active), .done_pulse(done_pulse)
  );

  seq_preamble_serializer #(.DATA_W(16), .GAP_CYCLES(3)) u_dut16 (
    .clock(clock), .reset(reset), .data_in(data_in16), .data_valid(data_valid16),
    .data_ready(data_ready16), .sequence_out(sequence_out16),
    .frame_active(frame_active16), .done_pulse(done_pulse16)
  );

  // Moore "1011" detector: 0=Zero 1="1" 2="10" 3="101" 4="1011"
  logic [2:0] det_state;
  logic       det_out;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) det_state <= 3'd0;
    else begin
      case (det_state)
        3'd0:    det_state <= sequence_out ? 3'd1 : 3'd0;
        3'd1:    det_state <= sequence_out ? 3'd1 : 3'd2;
        3'd2:    det_state <= sequence_out ? 3'd3 : 3'd0;
        3'd3:    det_state <= sequence_out ? 3'd4 : 3'd2;
        3'd4:    det_state <= sequence_out ? 3'd1 : 3'd2;
        default: det_state <= 3'd0;
      endcase
    end
  end
  assign det_out = (det_state == 3'd4);

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       seq;
    logic       ready;
    logic       active;
    logic       done;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic v, input logic [7:0] d, input logic s,
                      input logic r, input logic a, input logic dn);
    vec_t e;
    e.valid = v; e.data = d; e.seq = s; e.ready = r; e.active = a; e.done = dn;
    vq.push_back(e);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Entry j drives edge j and expects cycle j+1 of a frame accepted at edge 0.
  task automatic add_frame(input logic [7:0] word, input logic hv, input logic [7:0] hd);
    logic [3:0] pre;
    logic       s;
    int         c;
    pre = 4'b1011;
    for (int j = 0; j < 15; j++) begin
      c = j + 1;
      if (c <= 4)       s = pre[4-c];
      else if (c <= 12) s = word[12-c];
      else              s = 1'b0;
      push((j == 0) ? 1'b1 : hv, (j == 0) ? word : hd, s, c == 15, c < 15, c == 13);
    end
  endtask

  task automatic run_vectors(input string tag);
    foreach (vq[i]) begin
      data_valid = vq[i].valid;
      data_in    = vq[i].data;
      step();
      check($sformatf("%s[%0d] seq", tag, i),    sequence_out, vq[i].seq);
      check($sformatf("%s[%0d] ready", tag, i),  data_ready,   vq[i].ready);
      check($sformatf("%s[%0d] active", tag, i), frame_active, vq[i].active);
      check($sformatf("%s[%0d] done", tag, i),   done_pulse,   vq[i].done);
    end
    vq.delete();
    data_valid = 1'b0;
  endtask

  initial begin
    logic [22:0] e16;
    data_valid   = 1'b0;
    data_in      = 8'h00;
    data_valid16 = 1'b0;
    data_in16    = 16'h0000;
    #12;
    check("rst seq",    sequence_out, 1'b0);
    check("rst ready",  data_ready,   1'b1);
    check("rst active", frame_active, 1'b0);
    check("rst done",   done_pulse,   1'b0);
    reset = 1'b0;

    // idle, single frame with ignored mid-frame valids, back-to-back frames
    add_idle(10);
    add_frame(8'hA5, 1'b1, 8'hFF);
    add_idle(2);
    add_frame(8'h3C, 1'b1, 8'hC3);
    add_frame(8'hC3, 1'b0, 8'h00);
    add_idle(1);
    run_vectors("main");

    // detector loopback on an all-zero payload
    data_valid = 1'b1;
    data_in    = 8'h00;
    step();
    data_valid = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("det c%0d", c), det_out, (c == 5));
      if (c < 15) step();
    end
    check("det zero at gap end", det_state, 3'd0);

    // reset during DATA of an 8'hFF frame
    data_valid = 1'b1;
    data_in    = 8'hFF;
    step();
    data_valid = 1'b0;
    for (int c = 2; c <= 7; c++) step();
    check("mid seq before rst",    sequence_out, 1'b1);
    check("mid active before rst", frame_active, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid rst seq",    sequence_out, 1'b0);
    check("mid rst active", frame_active, 1'b0);
    check("mid rst ready",  data_ready,   1'b1);
    check("mid rst done",   done_pulse,   1'b0);
    #1 reset = 1'b0;
    add_idle(3);
    add_frame(8'h5A, 1'b0, 8'h00);
    add_idle(1);
    run_vectors("post_rst");

    // 16-bit payload, 3-cycle gap
    e16 = 23'b1011_1000000000000001_000;
    data_valid16 = 1'b1;
    data_in16    = 16'h8001;
    step();
    data_valid16 = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      check($sformatf("w16 c%0d seq", c),   sequence_out16, (c <= 23) ? e16[23-c] : 1'b0);
      check($sformatf("w16 c%0d done", c),  done_pulse16,   (c == 21));
      check($sformatf("w16 c%0d ready", c), data_ready16,   (c == 24));
      if (c < 24) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
